// File: rtl/pkt_demux_pkg.sv
// pkt_demux_pkg: shared types and constants for the packet demultiplexer.
package pkt_demux_pkg;
    localparam int DATA_W = 512;
    localparam int EMPTY_W = 6;
    localparam logic [1:0] DROP_DEST_DEF = 2'd3;

    typedef enum logic [1:0] {IDLE, FWD, DROP} route_t;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic [1:0]         dest;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);
endpackage

// File: rtl/avl_stream_if.sv
// avl_stream_if: Avalon-ST packet stream bundle with sink and source views.
interface avl_stream_if #(parameter int WIDTH = 512) ();
    localparam int EW = $clog2(WIDTH / 8);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             sop;
    logic             eop;
    logic [EW-1:0]    empty;
    modport rx (input valid, data, sop, eop, empty, output ready);
    modport tx (output valid, data, sop, eop, empty, input ready);
endinterface

// File: rtl/avlstrm_skid_buf.sv
// avlstrm_skid_buf: 2-entry buffer with registered ready and an empty-buffer bypass.
module avlstrm_skid_buf #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [1:0]   count;
    logic [1:0]   count_nx;
    logic [1:0]   wr;
    logic [W-1:0] mem [2];
    logic         push;
    logic         pop;

    assign push      = in_valid && in_ready;
    assign out_valid = count != 2'd0 || push;
    assign out_data  = count != 2'd0 ? mem[0] : in_data;
    assign pop       = out_valid && out_ready;
    assign count_nx  = count + {1'b0, push} - {1'b0, pop};
    assign wr        = count - {1'b0, pop};

    // ready looks at next occupancy, so a beat taken while it is still high always finds room
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            count    <= 2'd0;
            in_ready <= 1'b0;
        end else begin
            count    <= count_nx;
            in_ready <= (count_nx <= 2'd1);
        end
        if (pop)
            mem[0] <= mem[1];
        if (push && (count != 2'd0 || !pop))
            mem[wr[0]] <= in_data;
    end
endmodule

// File: rtl/pkt_demux_avlstrm.sv
// pkt_demux_avlstrm: packet-atomic 1-to-3 Avalon-ST demultiplexer with drop tag.
module pkt_demux_avlstrm
    import pkt_demux_pkg::*;
#(
    parameter logic [1:0] DROP_DEST = DROP_DEST_DEF
) (
    input  logic          Clk,
    input  logic          Rst_n,
    avl_stream_if.rx      in,
    input  logic [1:0]    in_dest,
    avl_stream_if.tx      out0,
    avl_stream_if.tx      out1,
    avl_stream_if.tx      out2,
    output logic [31:0]   drop_cnt,
    output logic [31:0]   err_cnt
);
    beat_t      in_beat;
    beat_t      sk_beat;
    beat_t      head;
    logic       sk_valid;
    logic       sk_ready;
    logic       head_valid;
    logic       sel_ready;
    logic       release_h;
    logic       is_err;
    logic       is_drop;
    logic       discard;
    logic       take;
    logic [1:0] sel;
    route_t     state;

    assign in_beat = {in.data, in.sop, in.eop, in.empty, in_dest};

    avlstrm_skid_buf #(.W(BEAT_W)) u_skid (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .in_valid  (in.valid),
        .in_ready  (in.ready),
        .in_data   (in_beat),
        .out_valid (sk_valid),
        .out_ready (sk_ready),
        .out_data  (sk_beat)
    );

    // an unmapped route (only possible with a non-default DROP_DEST) drains instead of hanging
    assign sel_ready = sel == 2'd0 ? out0.ready :
                       sel == 2'd1 ? out1.ready :
                       sel == 2'd2 ? out2.ready : 1'b1;
    assign release_h = head_valid && sel_ready;
    assign is_drop   = sk_beat.sop && sk_beat.dest == DROP_DEST;
    assign is_err    = sk_beat.sop ? state != IDLE : state == IDLE;
    assign discard   = is_drop || (!sk_beat.sop && state != FWD);
    assign sk_ready  = discard || !head_valid || sel_ready;
    assign take      = sk_valid && sk_ready;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state      <= IDLE;
            head_valid <= 1'b0;
            sel        <= 2'd0;
            drop_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            if (take && !discard)
                head_valid <= 1'b1;
            else if (release_h)
                head_valid <= 1'b0;
            if (take) begin
                if (!discard && sk_beat.sop)
                    sel <= sk_beat.dest;
                state    <= sk_beat.eop ? IDLE : sk_beat.sop ? (is_drop ? DROP : FWD) : state;
                drop_cnt <= drop_cnt + 32'(is_drop);
                err_cnt  <= err_cnt + 32'(is_err);
            end
        end
        if (take && !discard)
            head <= sk_beat;
    end

    assign out0.valid = head_valid && sel == 2'd0;
    assign out1.valid = head_valid && sel == 2'd1;
    assign out2.valid = head_valid && sel == 2'd2;
    assign out0.data  = head.data;
    assign out1.data  = head.data;
    assign out2.data  = head.data;
    assign out0.sop   = head.sop;
    assign out1.sop   = head.sop;
    assign out2.sop   = head.sop;
    assign out0.eop   = head.eop;
    assign out1.eop   = head.eop;
    assign out2.eop   = head.eop;
    assign out0.empty = head.empty;
    assign out1.empty = head.empty;
    assign out2.empty = head.empty;
endmodule

// File: tb/tb_pkt_demux_avlstrm.sv
// tb_pkt_demux_avlstrm: scoreboard bench for the packet demultiplexer.
module tb_pkt_demux_avlstrm;
    import pkt_demux_pkg::*;

    typedef struct packed {
        logic [511:0] data;
        logic         sop;
        logic         eop;
        logic [5:0]   empty;
    } exp_t;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic [1:0]   in_dest = 2'd0;
    logic [2:0]   out_rdy = 3'b111;
    logic [31:0]  drop_cnt;
    logic [31:0]  err_cnt;
    int           n_tests = 0;
    int           n_fail = 0;
    exp_t         q [3][$];
    route_t       m_state = IDLE;
    logic [1:0]   m_sel = 2'd0;
    int           exp_err = 0;
    int           exp_drop = 0;
    logic [2:0]   held = 3'b000;
    logic [511:0] held_data [3];
    logic         saw_low = 1'b0;
    exp_t         got;
    exp_t         want;
    logic [2:0]   vld;

    avl_stream_if #(.WIDTH(512)) in_if ();
    avl_stream_if #(.WIDTH(512)) o0 ();
    avl_stream_if #(.WIDTH(512)) o1 ();
    avl_stream_if #(.WIDTH(512)) o2 ();

    assign o0.ready = out_rdy[0];
    assign o1.ready = out_rdy[1];
    assign o2.ready = out_rdy[2];
    assign vld = {o2.valid, o1.valid, o0.valid};

    pkt_demux_avlstrm #(.DROP_DEST(2'd3)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .in       (in_if),
        .in_dest  (in_dest),
        .out0     (o0),
        .out1     (o1),
        .out2     (o2),
        .drop_cnt (drop_cnt),
        .err_cnt  (err_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t snap(input int k);
        case (k)
            0:       return {o0.data, o0.sop, o0.eop, o0.empty};
            1:       return {o1.data, o1.sop, o1.eop, o1.empty};
            default: return {o2.data, o2.sop, o2.eop, o2.empty};
        endcase
    endfunction

    // reference routing: what each accepted beat should become
    task automatic model(input logic [511:0] d, input logic s, input logic e, input logic [5:0] emp, input logic [1:0] dst);
        if (s) begin
            if (m_state != IDLE) exp_err++;
            if (dst == 2'd3) begin
                exp_drop++;
                m_state = e ? IDLE : DROP;
            end else begin
                m_sel = dst;
                q[dst].push_back({d, s, e, emp});
                m_state = e ? IDLE : FWD;
            end
        end else if (m_state == IDLE) begin
            exp_err++;
        end else begin
            if (m_state == FWD) q[m_sel].push_back({d, s, e, emp});
            if (e) m_state = IDLE;
        end
    endtask

    task automatic send(input logic [511:0] d, input logic s, input logic e, input logic [5:0] emp, input logic [1:0] dst, output int waits);
        in_if.valid = 1'b1;
        in_if.data  = d;
        in_if.sop   = s;
        in_if.eop   = e;
        in_if.empty = emp;
        in_dest     = dst;
        waits = 0;
        @(negedge Clk);
        while (!in_if.ready) begin
            waits++;
            if (waits > 500) begin
                $display("FAIL in_ready_timeout: got 0 expected 1");
                $fatal(1, "input stalled");
            end
            @(negedge Clk);
        end
        @(posedge Clk);
        #1;
        in_if.valid = 1'b0;
        model(d, s, e, emp, dst);
    endtask

    task automatic pkt(input logic [1:0] dst, input int n, input logic [511:0] base, input logic [5:0] last_empty, output int waits);
        int w;
        waits = 0;
        for (int i = 0; i < n; i++) begin
            send(base + 512'(i), i == 0, i == n - 1, i == n - 1 ? last_empty : 6'd0, dst, w);
            waits += w;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 300) begin
            @(posedge Clk);
            n++;
        end
        repeat (2) @(posedge Clk);
        #1;
        check(tag, q[0].size() + q[1].size() + q[2].size(), 0);
    endtask

    always @(negedge Clk) begin
        if (Rst_n) begin
            if (!in_if.ready) saw_low = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (vld[k]) begin
                    got = snap(k);
                    if (held[k]) check($sformatf("hold%0d", k), got.data, held_data[k]);
                    held[k] = !out_rdy[k];
                    held_data[k] = got.data;
                    if (out_rdy[k]) begin
                        check($sformatf("avail%0d", k), q[k].size() != 0, 1);
                        if (q[k].size() != 0) begin
                            want = q[k].pop_front();
                            check($sformatf("data%0d", k), got.data, want.data);
                            check($sformatf("ctl%0d", k), {got.sop, got.eop, got.empty}, {want.sop, want.eop, want.empty});
                        end
                    end
                end else begin
                    held[k] = 1'b0;
                end
            end
        end
    end

    initial begin
        int w;
        int wsum;
        logic [1:0] dsts [4];
        dsts[0] = 2'd0; dsts[1] = 2'd1; dsts[2] = 2'd2; dsts[3] = 2'd0;
        in_if.valid = 1'b0;
        in_if.data  = '0;
        in_if.sop   = 1'b0;
        in_if.eop   = 1'b0;
        in_if.empty = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_ready", in_if.ready, 0);
        check("rst_valid", vld, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_err", err_cnt, 0);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        check("ready_rise", in_if.ready, 1);

        // 3-beat packet to out1, first beat visible one cycle after acceptance
        send(512'h1000, 1'b1, 1'b0, 6'd0, 2'd1, w);
        check("lat_v1", o1.valid, 1);
        check("lat_v02", {o2.valid, o0.valid}, 0);
        check("lat_sop", o1.sop, 1);
        send(512'h1001, 1'b0, 1'b0, 6'd0, 2'd1, w);
        send(512'h1002, 1'b0, 1'b1, 6'd12, 2'd1, w);
        drain("drain_p3");

        // back-to-back single-beat packets
        wsum = 0;
        for (int i = 0; i < 4; i++) begin
            send(512'h2000 + 512'(i), 1'b1, 1'b1, 6'(i), dsts[i], w);
            wsum += w;
        end
        check("b2b_ready", wsum, 0);
        drain("drain_b2b");

        // dropped packet then a single beat to out2
        pkt(2'd3, 4, 512'h3000, 6'd5, w);
        pkt(2'd2, 1, 512'h3100, 6'd7, w);
        drain("drain_drop");
        check("drop_cnt", drop_cnt, 32'(exp_drop));
        check("drop_err", err_cnt, 32'(exp_err));

        // out0 stalled mid-packet
        saw_low = 1'b0;
        fork
            pkt(2'd0, 8, 512'h4000, 6'd3, w);
            begin
                repeat (3) @(posedge Clk);
                #1;
                out_rdy[0] = 1'b0;
                repeat (5) @(posedge Clk);
                #1;
                out_rdy[0] = 1'b1;
            end
        join
        drain("drain_stall");
        check("stall_ready_low", saw_low, 1);

        // framing errors: body beat in IDLE, then sop inside a FWD packet
        send(512'h5000, 1'b0, 1'b0, 6'd0, 2'd0, w);
        send(512'h5100, 1'b1, 1'b0, 6'd0, 2'd0, w);
        send(512'h5101, 1'b0, 1'b0, 6'd0, 2'd0, w);
        pkt(2'd2, 2, 512'h5200, 6'd9, w);
        drain("drain_err");
        check("err_cnt", err_cnt, 32'(exp_err));
        check("err_drop", drop_cnt, 32'(exp_drop));

        // sop inside a dropped packet carrying the drop tag hits both counters
        send(512'h5300, 1'b1, 1'b0, 6'd0, 2'd3, w);
        send(512'h5301, 1'b1, 1'b1, 6'd0, 2'd3, w);
        repeat (2) @(posedge Clk);
        #1;
        check("both_err", err_cnt, 32'(exp_err));
        check("both_drop", drop_cnt, 32'(exp_drop));

        // reset pulse mid-packet
        out_rdy[1] = 1'b0;
        send(512'h6000, 1'b1, 1'b0, 6'd0, 2'd1, w);
        send(512'h6001, 1'b0, 1'b0, 6'd0, 2'd1, w);
        @(posedge Clk);
        #1;
        Rst_n = 1'b0;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        for (int k = 0; k < 3; k++) q[k].delete();
        held = 3'b000;
        m_state = IDLE;
        exp_err = 0;
        exp_drop = 0;
        out_rdy = 3'b111;
        check("mrst_valid", vld, 0);
        check("mrst_drop", drop_cnt, 0);
        check("mrst_err", err_cnt, 0);
        check("mrst_ready", in_if.ready, 0);
        pkt(2'd2, 2, 512'h7000, 6'd1, w);
        drain("drain_post_rst");
        check("post_err", err_cnt, 32'(exp_err));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
